// File: rtl/uart_mmio_if.sv
// Register-bus bundle for uart_mmio: a single write port and a combinational read port.
interface uart_mmio_if;
  logic        we;
  logic [2:0]  reg_num;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, output reg_num, output wd, input rd);
  modport slave  (input we, input reg_num, input wd, output rd);
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART with programmable bit period (BRR+1 clocks) and an RX interrupt.
// Define UART_PARITY_EN to add an optional parity bit controlled by CTRL[2] (enable) and CTRL[3] (odd).
module uart_mmio #(
  parameter logic [15:0] BRR_RESET   = 16'd867,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_mmio_if.slave bus,
  input  logic       rx,
  output logic       tx,
  output logic       irq
);

`ifdef UART_PARITY_EN
  localparam int unsigned CtrlW = 4;
`else
  localparam int unsigned CtrlW = 2;
`endif

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  logic [CtrlW-1:0]       ctrl_q;
  logic [15:0]            brr_q;
  logic [7:0]             rxdata_q, rxdata_d;
  logic                   rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d, par_err_q, par_err_d;
  logic                   par_en, par_odd, en_d, tx_busy;
  logic                   wr_ctrl, wr_status, wr_brr, wr_txdata;
  logic [3:0]             w1c;

  tx_state_e              tx_state_q, tx_state_d;
  logic [15:0]            tx_cnt_q, tx_cnt_d;
  logic [2:0]             tx_bit_q, tx_bit_d;
  logic [7:0]             tx_shift_q, tx_shift_d;
  logic                   tx_par_q, tx_par_d, tx_done;

  rx_state_e              rx_state_q, rx_state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_armed_q, rx_armed_d, rx_par_bad_q, rx_par_bad_d, rx_store;
  logic [15:0]            rx_cnt_q, rx_cnt_d;
  logic [2:0]             rx_bit_q, rx_bit_d;
  logic [7:0]             rx_shift_q, rx_shift_d;
  logic                   rx_done;

`ifdef UART_PARITY_EN
  assign par_en  = ctrl_q[2];
  assign par_odd = ctrl_q[3];
`else
  assign par_en  = 1'b0;
  assign par_odd = 1'b0;
`endif

  assign wr_ctrl   = bus.we && (bus.reg_num == 3'd0);
  assign wr_status = bus.we && (bus.reg_num == 3'd1);
  assign wr_brr    = bus.we && (bus.reg_num == 3'd2);
  assign wr_txdata = bus.we && (bus.reg_num == 3'd3);
  // Enable as it will be after this edge, so clearing it aborts both FSMs on the same edge.
  assign en_d      = wr_ctrl ? bus.wd[0] : ctrl_q[0];
  assign tx_busy   = (tx_state_q != TxIdle);
  assign irq       = rx_valid_q & ctrl_q[1];
  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign tx_done   = (tx_cnt_q >= brr_q);
  assign rx_done   = (rx_cnt_q >= brr_q);
  assign w1c       = wr_status ? bus.wd[4:1] : 4'b0;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    if (tx_state_q != TxIdle) tx_cnt_d = tx_done ? 16'd0 : tx_cnt_q + 16'd1;
    unique case (tx_state_q)
      TxIdle: if (wr_txdata && ctrl_q[0]) begin
        tx_state_d = TxStart;
        tx_shift_d = bus.wd[7:0];
        tx_par_d   = (^bus.wd[7:0]) ^ par_odd;
        tx_bit_d   = 3'd0;
        tx_cnt_d   = 16'd0;
      end
      TxStart:  if (tx_done) tx_state_d = TxData;
      TxData: if (tx_done) begin
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        if (tx_bit_q == 3'd7) tx_state_d = par_en ? TxParity : TxStop;
        else                  tx_bit_d   = tx_bit_q + 3'd1;
      end
      TxParity: if (tx_done) tx_state_d = TxStop;
      TxStop:   if (tx_done) tx_state_d = TxIdle;
      default:  tx_state_d = TxIdle;
    endcase
    if (!en_d) begin
      tx_state_d = TxIdle;
      tx_cnt_d   = 16'd0;
    end
  end

  always_comb begin
    unique case (tx_state_q)
      TxStart:  tx = 1'b0;
      TxData:   tx = tx_shift_q[0];
      TxParity: tx = tx_par_q;
      default:  tx = 1'b1;
    endcase
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_par_bad_d = rx_par_bad_q;
    rx_armed_d   = rx_armed_q | rx_s;
    rx_store     = 1'b0;
    unique case (rx_state_q)
      RxIdle: if (ctrl_q[0] && rx_armed_q && !rx_s) begin
        rx_state_d = RxStart;
        rx_cnt_d   = 16'd0;
      end
      RxStart: if (rx_cnt_q >= {1'b0, brr_q[15:1]}) begin
        rx_cnt_d     = 16'd0;
        rx_bit_d     = 3'd0;
        rx_par_bad_d = 1'b0;
        rx_state_d   = rx_s ? RxIdle : RxData;
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      RxData: if (rx_done) begin
        rx_cnt_d   = 16'd0;
        rx_shift_d = {rx_s, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = par_en ? RxParity : RxStop;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      RxParity: if (rx_done) begin
        rx_cnt_d     = 16'd0;
        rx_par_bad_d = rx_s ^ (^rx_shift_q) ^ par_odd;
        rx_state_d   = RxStop;
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      RxStop: if (rx_done) begin
        rx_cnt_d   = 16'd0;
        rx_store   = 1'b1;
        rx_armed_d = 1'b0;
        rx_state_d = RxIdle;
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      default: rx_state_d = RxIdle;
    endcase
    if (!en_d) begin
      rx_state_d = RxIdle;
      rx_cnt_d   = 16'd0;
      rx_store   = 1'b0;
    end
  end

  // Hardware set beats a same-cycle W1C of the same bit.
  always_comb begin
    rx_valid_d  = (rx_valid_q & ~w1c[0]) | rx_store;
    frame_err_d = (frame_err_q & ~w1c[1]) | (rx_store & ~rx_s);
    overrun_d   = (overrun_q & ~w1c[2]) | (rx_store & rx_valid_q);
    par_err_d   = (par_err_q & ~w1c[3]) | (rx_store & rx_par_bad_q);
    rxdata_d    = rx_store ? rx_shift_q : rxdata_q;
  end

  always_comb begin
    unique case (bus.reg_num)
      3'd0:    bus.rd = 32'(ctrl_q);
      3'd1:    bus.rd = {27'd0, par_err_q, overrun_q, frame_err_q, rx_valid_q, tx_busy};
      3'd2:    bus.rd = {16'd0, brr_q};
      3'd4:    bus.rd = {24'd0, rxdata_q};
      default: bus.rd = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q       <= '0;
      brr_q        <= BRR_RESET;
      rxdata_q     <= 8'd0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      par_err_q    <= 1'b0;
      tx_state_q   <= TxIdle;
      tx_cnt_q     <= 16'd0;
      tx_bit_q     <= 3'd0;
      tx_shift_q   <= 8'd0;
      tx_par_q     <= 1'b0;
      rx_state_q   <= RxIdle;
      sync_q       <= '1;
      rx_armed_q   <= 1'b0;
      rx_par_bad_q <= 1'b0;
      rx_cnt_q     <= 16'd0;
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= 8'd0;
    end else begin
      if (wr_ctrl) ctrl_q <= bus.wd[CtrlW-1:0];
      if (wr_brr)  brr_q  <= bus.wd[15:0];
      rxdata_q     <= rxdata_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      par_err_q    <= par_err_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_par_q     <= tx_par_d;
      rx_state_q   <= rx_state_d;
      sync_q       <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_armed_q   <= rx_armed_d;
      rx_par_bad_q <= rx_par_bad_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: register access, TX/RX framing, error flags, abort, reset.
module tb_uart_mmio;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic tx, irq;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];

  uart_mmio_if bus ();

  uart_mmio dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .rx    (rx),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we = 1'b1; bus.reg_num = a; bus.wd = d;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus.reg_num = a;
    #1 check(tag, bus.rd, exp);
  endtask

  // Drives one frame at bit_clks clocks per bit, starting on a negedge.
  task automatic rx_send(input logic [7:0] b, input logic stop, input int bit_clks);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    rx_exp_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (bit_clks) @(negedge clk);
    end
    rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic rx_pop_check(input string tag);
    logic [7:0] e;
    if (rx_exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = rx_exp_q.pop_front();
      check_reg(tag, 3'd4, {24'd0, e});
    end
  endtask

  initial begin
    logic [7:0]  b;
    logic [9:0]  frame;
    logic [9:0]  cap;
    logic        all_high;

    bus.we = 1'b0; bus.reg_num = 3'd0; bus.wd = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check_reg("rst_ctrl", 3'd0, 32'd0);
    check_reg("rst_status", 3'd1, 32'd0);
    check_reg("rst_brr", 3'd2, 32'd867);
    check_reg("rst_txdata", 3'd3, 32'd0);
    check_reg("rst_rxdata", 3'd4, 32'd0);
    check_reg("rst_unmapped", 3'd7, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // TX frame at 2 clocks/bit with a write attempted while busy.
    reg_write(3'd2, 32'd1);
    reg_write(3'd0, 32'd1);
    check_reg("ctrl_rw", 3'd0, 32'd1);
    tx_exp_q.push_back(8'h5F);
    reg_write(3'd3, 32'h5F);
    b = tx_exp_q.pop_front();
    frame = {1'b1, b, 1'b0};
    cap = '0;
    for (int k = 0; k < 20; k++) begin
      check($sformatf("tx_bit%0d", k), {31'd0, tx}, {31'd0, frame[k/2]});
      if (k % 2 == 1) cap[k/2] = tx;
      if (k == 0 || k == 19) check_reg("tx_busy", 3'd1, 32'd1);
      if (k == 6) begin
        bus.reg_num = 3'd3; bus.wd = 32'hAA; bus.we = 1'b1;
      end else begin
        bus.we = 1'b0;
      end
      @(negedge clk);
    end
    bus.we = 1'b0;
    check("tx_byte", {24'd0, cap[8:1]}, {24'd0, b});
    check("tx_end_high", {31'd0, tx}, 32'd1);
    check_reg("tx_not_busy", 3'd1, 32'd0);
    all_high = 1'b1;
    repeat (12) begin
      if (tx !== 1'b1) all_high = 1'b0;
      @(negedge clk);
    end
    check("tx_busy_write_ignored", {31'd0, all_high}, 32'd1);

    // RX at 2 clocks/bit with interrupt enabled.
    reg_write(3'd0, 32'd3);
    rx_send(8'hA5, 1'b1, 2);
    rx_pop_check("rx_a5");
    check_reg("rx_status", 3'd1, 32'h2);
    check("rx_irq", {31'd0, irq}, 32'd1);
    reg_write(3'd1, 32'h2);
    check_reg("rx_w1c", 3'd1, 32'h0);
    check("rx_irq_clr", {31'd0, irq}, 32'd0);

    // Framing error, then overrun.
    rx_send(8'h12, 1'b0, 2);
    rx_pop_check("rx_ferr_byte");
    check_reg("rx_ferr_status", 3'd1, 32'h6);
    reg_write(3'd1, 32'h1E);
    check_reg("status_clr_all", 3'd1, 32'h0);
    rx_send(8'h11, 1'b1, 2);
    rx_pop_check("rx_11");
    check_reg("rx_11_status", 3'd1, 32'h2);
    rx_send(8'h3C, 1'b1, 2);
    rx_pop_check("rx_ovr_byte");
    check_reg("rx_ovr_status", 3'd1, 32'hA);
    reg_write(3'd1, 32'h1E);

    // Glitch shorter than half a bit is rejected.
    reg_write(3'd2, 32'd7);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (120) @(negedge clk);
    check_reg("false_start_status", 3'd1, 32'h0);
    check_reg("false_start_rxdata", 3'd4, 32'h3C);
    check("false_start_irq", {31'd0, irq}, 32'd0);

    // Abort TX by clearing enable mid-frame.
    reg_write(3'd2, 32'd3);
    reg_write(3'd0, 32'd1);
    reg_write(3'd3, 32'h00);
    repeat (6) @(negedge clk);
    check("abort_mid_low", {31'd0, tx}, 32'd0);
    reg_write(3'd0, 32'd0);
    check("abort_tx_high", {31'd0, tx}, 32'd1);
    check_reg("abort_not_busy", 3'd1, 32'h0);
    reg_write(3'd3, 32'h00);
    check("disabled_tx_ignored", {31'd0, tx}, 32'd1);

    // Reset asserted mid-frame.
    reg_write(3'd0, 32'd1);
    reg_write(3'd3, 32'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 check("midrst_tx", {31'd0, tx}, 32'd1);
    check_reg("midrst_brr", 3'd2, 32'd867);
    check_reg("midrst_ctrl", 3'd0, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    check("tx_sb_drained", tx_exp_q.size(), 32'd0);
    check("rx_sb_drained", rx_exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
